// File: rtl/fpga_spi_link_pkg.sv
// Shared types, default widths and helpers for the FPGA-side SPI link host.
// SPI_LINK_PARITY_EN adds one even-parity bit to each TX frame and each RX reply.
package fpga_spi_link_pkg;

    typedef enum logic [2:0] {StIdle, StTx, StTurn, StRx, StGap} spi_state_e;

    localparam int unsigned CMD_W_DEF  = 8;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned RSP_W_DEF  = 16;
    localparam int unsigned TURN_DEF   = 2;
    localparam int unsigned GAP_DEF    = 2;
    localparam int unsigned FRAME_W    = CMD_W_DEF + DATA_W_DEF;

`ifdef SPI_LINK_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_par(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/fpga_spi_link_host_if.sv
// Command/response port of the SPI link host; the master side is the host register logic.
// rsp_perr exists only when SPI_LINK_PARITY_EN is defined.
interface fpga_spi_link_host_if
    import fpga_spi_link_pkg::*;
#(
    parameter int unsigned CMD_W  = CMD_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RSP_W  = RSP_W_DEF
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_read;
    logic              rsp_valid;
    logic [RSP_W-1:0]  rsp_data;
`ifdef SPI_LINK_PARITY_EN
    logic              rsp_perr;
`endif

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_read,
        input  cmd_ready, rsp_valid, rsp_data
`ifdef SPI_LINK_PARITY_EN
        , rsp_perr
`endif
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_read,
        output cmd_ready, rsp_valid, rsp_data
`ifdef SPI_LINK_PARITY_EN
        , rsp_perr
`endif
    );

endinterface

// File: rtl/spi_link_shifter.sv
// Loadable MSB-first shift register; shifts serial data in at the LSB end.
// Shared by the TX (load then shift out) and RX (shift in) phases of a frame.
module spi_link_shifter #(
    parameter int unsigned W = 24
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         shift_i,
    input  logic         sdi_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = {data_q[W-2:0], sdi_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/fpga_spi_link_host.sv
// FPGA-side SPI link host: frames a command onto SPI_FtoC under CS and captures read replies.
// Optional SPI_LINK_PARITY_EN appends a parity bit to TX frames and checks one on replies.
module fpga_spi_link_host
    import fpga_spi_link_pkg::*;
#(
    parameter int unsigned CMD_W  = CMD_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RSP_W  = RSP_W_DEF,
    parameter int unsigned TURN   = TURN_DEF,
    parameter int unsigned GAP    = GAP_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    fpga_spi_link_host_if.slave  cmd_if,
    output logic                 busy,
    output logic                 CS,
    output logic                 SPI_FtoC,
    input  logic                 SPI_CtoF
);

    localparam int unsigned FrameW = CMD_W + DATA_W;
    localparam int unsigned TxLen  = FrameW + PAR_W;
    localparam int unsigned RxLen  = RSP_W + PAR_W;
    localparam int unsigned ShW    = max2(TxLen, RxLen);
    localparam int unsigned CntW   = $clog2(max2(ShW, max2(TURN, GAP)) + 1);

    spi_state_e       state_q;
    logic [CntW-1:0]  cnt_q;
    logic             ready_q, busy_q, cs_q, sdo_q, read_q, rsp_valid_q;
    logic [RSP_W-1:0] rsp_data_q;
`ifdef SPI_LINK_PARITY_EN
    logic             perr_q;
`endif

    logic [TxLen-1:0] tx_frame;
    logic [ShW-1:0]   sh_data;
    logic [RxLen-1:0] rx_next;
    logic             handshake, sh_shift;
    logic             unused_sh;

`ifdef SPI_LINK_PARITY_EN
    assign tx_frame = {cmd_if.cmd_op, cmd_if.cmd_data,
                       even_par(64'({cmd_if.cmd_op, cmd_if.cmd_data}))};
`else
    assign tx_frame = {cmd_if.cmd_op, cmd_if.cmd_data};
`endif

    always_comb begin
        handshake = (state_q == StIdle) && ready_q && cmd_if.cmd_valid;
        sh_shift  = (state_q == StTx) || (state_q == StRx);
        // Include the bit being sampled on this edge so the reply is complete at the last edge.
        rx_next   = {sh_data[RxLen-2:0], SPI_CtoF};
    end

    spi_link_shifter #(
        .W (ShW)
    ) u_shifter (
        .clk_i       (clk),
        .reset_i     (reset),
        .load_i      (handshake),
        .load_data_i (ShW'(tx_frame) << (ShW - TxLen)),
        .shift_i     (sh_shift),
        .sdi_i       (SPI_CtoF),
        .data_o      (sh_data)
    );

    assign unused_sh = ^sh_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            cs_q        <= 1'b1;
            sdo_q       <= 1'b0;
            read_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef SPI_LINK_PARITY_EN
            perr_q      <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (handshake) begin
                        state_q <= StTx;
                        cnt_q   <= CntW'(TxLen - 1);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b0;
                        sdo_q   <= tx_frame[TxLen-1];
                        read_q  <= cmd_if.cmd_read;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StTx: begin
                    if (cnt_q == '0) begin
                        sdo_q <= 1'b0;
                        if (read_q) begin
                            state_q <= StTurn;
                            cnt_q   <= CntW'(TURN - 1);
                        end else begin
                            state_q <= StGap;
                            cnt_q   <= CntW'(GAP - 1);
                            cs_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                        sdo_q <= sh_data[ShW-2];
                    end
                end
                StTurn: begin
                    if (cnt_q == '0) begin
                        state_q <= StRx;
                        cnt_q   <= CntW'(RxLen - 1);
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StRx: begin
                    if (cnt_q == '0) begin
                        state_q     <= StGap;
                        cnt_q       <= CntW'(GAP - 1);
                        cs_q        <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rx_next[RxLen-1 -: RSP_W];
`ifdef SPI_LINK_PARITY_EN
                        perr_q      <= rx_next[0] ^ even_par(64'(rx_next[RxLen-1:1]));
`endif
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StGap: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_if.cmd_ready = ready_q;
    assign cmd_if.rsp_valid = rsp_valid_q;
    assign cmd_if.rsp_data  = rsp_data_q;
`ifdef SPI_LINK_PARITY_EN
    assign cmd_if.rsp_perr  = perr_q;
`endif
    assign busy     = busy_q;
    assign CS       = cs_q;
    assign SPI_FtoC = sdo_q;

endmodule

// File: tb/tb_fpga_spi_link_host.sv
// Directed bench for fpga_spi_link_host: write, read, back-to-back, mid-frame reset.
// Expected frame bits and cycle positions are hand-derived; parity cases need SPI_LINK_PARITY_EN.
module tb_fpga_spi_link_host;

`ifdef SPI_LINK_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int TX_N     = 24 + PAR;
    localparam int RX_N     = 16 + PAR;
    localparam int RX_FIRST = TX_N + 3;          // two turnaround cycles follow the TX bits
    localparam int FRAME_RD = TX_N + 2 + RX_N;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic SPI_CtoF = 1'b0;
    logic busy, CS, SPI_FtoC;

    int n_chk = 0;
    int n_err = 0;

    logic cs_h  [0:127];
    logic fto_h [0:127];
    logic rv_h  [0:127];
    logic rdy_h [0:127];

    fpga_spi_link_host_if u_if ();

    fpga_spi_link_host u_dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_if   (u_if),
        .busy     (busy),
        .CS       (CS),
        .SPI_FtoC (SPI_FtoC),
        .SPI_CtoF (SPI_CtoF)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_frame(input logic [7:0] op, input logic [15:0] data,
                                              input logic p);
        if (PAR != 0) return {7'd0, op, data, p};
        return {8'd0, op, data};
    endfunction

    function automatic logic [16:0] rx_word(input logic [15:0] r, input logic p);
        if (PAR != 0) return {r, p};
        return {1'b0, r};
    endfunction

    function automatic logic [31:0] tx_bits(input int first, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w = {w[30:0], fto_h[first+i]};
        return w;
    endfunction

    function automatic int count_low(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) if (cs_h[i] == 1'b0) c++;
        return c;
    endfunction

    function automatic int count_set(input int a, input int b, input int which);
        int c = 0;
        for (int i = a; i <= b; i++) begin
            if (which == 0 && rv_h[i])  c++;
            if (which == 1 && rdy_h[i]) c++;
            if (which == 2 && fto_h[i]) c++;
        end
        return c;
    endfunction

    // Records cycles T+1..T+n after a handshake in cycle T; plays the chip's reply from rx_first.
    task automatic run_cycles(input int n, input logic [16:0] rxw, input int rx_first);
        for (int k = 1; k <= n; k++) begin
            cs_h[k]  = CS;
            fto_h[k] = SPI_FtoC;
            rv_h[k]  = u_if.rsp_valid;
            rdy_h[k] = u_if.cmd_ready;
            if (k >= rx_first && k < rx_first + RX_N) SPI_CtoF = rxw[RX_N-1-(k-rx_first)];
            else SPI_CtoF = 1'b0;
            tick();
        end
        SPI_CtoF = 1'b0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [15:0] data, input logic rd);
        u_if.cmd_valid = 1'b1;
        u_if.cmd_op    = op;
        u_if.cmd_data  = data;
        u_if.cmd_read  = rd;
        tick();
        u_if.cmd_valid = 1'b0;
    endtask

    task automatic read_frame(input string tag, input logic [15:0] reply, input logic p);
        check_eq({tag, "_ready"}, u_if.cmd_ready, 1);
        issue(8'h3C, 16'h0000, 1'b1);
        run_cycles(FRAME_RD + 3, rx_word(reply, p), RX_FIRST);
        check_eq({tag, "_rv_cnt"}, count_set(1, FRAME_RD + 3, 0), 1);
        check_eq({tag, "_rv_pos"}, rv_h[FRAME_RD+1], 1);
        check_eq({tag, "_data"}, u_if.rsp_data, reply);
    endtask

    initial begin
        u_if.cmd_valid = 1'b0;
        u_if.cmd_op    = '0;
        u_if.cmd_data  = '0;
        u_if.cmd_read  = 1'b0;
        repeat (3) tick();
        check_eq("rst_ready_in_reset", u_if.cmd_ready, 0);
        reset = 1'b0;
        tick();
        check_eq("rst_cs", CS, 1);
        check_eq("rst_fto", SPI_FtoC, 0);
        check_eq("rst_rv", u_if.rsp_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rdata", u_if.rsp_data, 0);
        check_eq("rst_ready_after", u_if.cmd_ready, 1);

        // Write A5/1234: parity over 0xA51234 has nine ones -> parity bit 1.
        issue(8'hA5, 16'h1234, 1'b0);
        check_eq("wr_busy", busy, 1);
        run_cycles(TX_N + 3, 17'd0, 999);
        check_eq("wr_bits", tx_bits(1, TX_N), exp_frame(8'hA5, 16'h1234, 1'b1));
        check_eq("wr_cs_low", count_low(1, TX_N), TX_N);
        check_eq("wr_cs_gap", count_low(TX_N + 1, TX_N + 2), 0);
        check_eq("wr_fto_gap", fto_h[TX_N+1], 0);
        check_eq("wr_ready_gap", rdy_h[TX_N+2], 0);
        check_eq("wr_ready_idle", rdy_h[TX_N+3], 1);
        check_eq("wr_no_rv", count_set(1, TX_N + 3, 0), 0);

        // Read 3C, chip returns BEEF (13 ones -> parity bit 1).
        read_frame("rd", 16'hBEEF, 1'b1);
        check_eq("rd_bits", tx_bits(1, TX_N), exp_frame(8'h3C, 16'h0000, 1'b0));
        check_eq("rd_cs_low", count_low(1, FRAME_RD), FRAME_RD);
        check_eq("rd_cs_end", cs_h[FRAME_RD+1], 1);
        check_eq("rd_fto_quiet", count_set(TX_N + 1, FRAME_RD + 3, 2), 0);
`ifdef SPI_LINK_PARITY_EN
        check_eq("rd_perr", u_if.rsp_perr, 0);
`endif

        // cmd_valid held across a whole frame; fields change mid-frame to the queued command.
        u_if.cmd_valid = 1'b1;
        u_if.cmd_op    = 8'h11;
        u_if.cmd_data  = 16'h2222;
        u_if.cmd_read  = 1'b0;
        tick();
        for (int k = 1; k <= 2 * TX_N + 6; k++) begin
            cs_h[k]  = CS;
            fto_h[k] = SPI_FtoC;
            rdy_h[k] = u_if.cmd_ready;
            rv_h[k]  = u_if.rsp_valid;
            if (k == 5) begin
                u_if.cmd_op   = 8'h33;
                u_if.cmd_data = 16'h4444;
            end
            tick();
            if (k == TX_N + 3) u_if.cmd_valid = 1'b0;
        end
        check_eq("b2b_ready_busy", count_set(1, TX_N + 2, 1), 0);
        check_eq("b2b_a_bits", tx_bits(1, TX_N), exp_frame(8'h11, 16'h2222, 1'b0));
        // Two GAP cycles plus the IDLE handshake cycle separate the frames.
        check_eq("b2b_cs_high", count_low(TX_N + 1, TX_N + 3), 0);
        check_eq("b2b_restart", cs_h[TX_N+4], 0);
        check_eq("b2b_b_bits", tx_bits(TX_N + 4, TX_N), exp_frame(8'h33, 16'h4444, 1'b0));
        check_eq("b2b_cs_low2", count_low(TX_N + 4, 2 * TX_N + 3), TX_N);

        // Reset pulse in cycle T+10 of a read.
        issue(8'h3C, 16'h0000, 1'b1);
        run_cycles(9, rx_word(16'hBEEF, 1'b1), RX_FIRST);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mr_cs", CS, 1);
        check_eq("mr_fto", SPI_FtoC, 0);
        check_eq("mr_busy", busy, 0);
        run_cycles(FRAME_RD, rx_word(16'hBEEF, 1'b1), RX_FIRST - 10);
        check_eq("mr_no_rv", count_set(1, FRAME_RD, 0), 0);
        check_eq("mr_rdata", u_if.rsp_data, 0);
        read_frame("mr_next", 16'h5A5A, 1'b0);

`ifdef SPI_LINK_PARITY_EN
        read_frame("par0", 16'h0001, 1'b0);
        check_eq("par0_perr", u_if.rsp_perr, 1);
        read_frame("par1", 16'h0001, 1'b1);
        check_eq("par1_perr", u_if.rsp_perr, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
